controlador_bus_rtc: RTL and testbench

- Bus master for the RTC chip's multiplexed address/data parallel bus.
- Turns one-cycle requests from the PicoBlaze-side RTC register block into complete write or read cycles: address phase, separation, data phase, hold.
- On completion it returns a one-cycle `listo` strobe and, for reads, the captured byte. That byte feeds the register block's RTC input path.

---
 rtl/controlador_bus_rtc.sv | 162 ++++++++++++++++
 tb/tb_controlador_bus_rtc.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_bus_rtc.sv
// Bus master for the RTC multiplexed address/data bus.
// Runs one address phase and one data phase per request, then pulses listo.
module controlador_bus_rtc #(
  parameter int N_FASE = 10,
  parameter int N_SEP  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       escribir,
  input  logic [7:0] direccion,
  input  logic [7:0] dato_es,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] dato_leido,
  output logic       ocupado,
  output logic       listo
);

  localparam logic [7:0] FASE_M1 = 8'(N_FASE - 1);
  localparam logic [7:0] SEP_M1  = 8'(N_SEP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIR,
    S_SEP1,
    S_DATO,
    S_SEP2,
    S_LISTO
  } estado_t;

  estado_t     estado_q;
  logic [7:0]  cnt_q;
  logic        esc_q;
  logic [7:0]  dir_q;
  logic [7:0]  dat_q;
  logic [7:0]  ad_out_q;
  logic        ad_oe_q;
  logic        cs_n_q;
  logic        rd_n_q;
  logic        wr_n_q;
  logic        a_d_q;
  logic [7:0]  leido_q;
  logic        ocupado_q;
  logic        listo_q;

  // Phase sequencer; every bus pin is set on the edge entering its phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q  <= S_IDLE;
      cnt_q     <= 8'd0;
      esc_q     <= 1'b0;
      dir_q     <= 8'd0;
      dat_q     <= 8'd0;
      ad_out_q  <= 8'd0;
      ad_oe_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      a_d_q     <= 1'b1;
      leido_q   <= 8'd0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      unique case (estado_q)
        S_IDLE: begin
          if (inicio) begin
            esc_q     <= escribir;
            dir_q     <= direccion;
            dat_q     <= dato_es;
            estado_q  <= S_DIR;
            cnt_q     <= FASE_M1;
            cs_n_q    <= 1'b0;
            wr_n_q    <= 1'b0;
            rd_n_q    <= 1'b1;
            a_d_q     <= 1'b0;
            ad_oe_q   <= 1'b1;
            ad_out_q  <= direccion;
            ocupado_q <= 1'b1;
          end
        end
        S_DIR: begin
          if (cnt_q == 8'd0) begin
            estado_q <= S_SEP1;
            cnt_q    <= SEP_M1;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_SEP1: begin
          if (cnt_q == 8'd0) begin
            estado_q <= S_DATO;
            cnt_q    <= FASE_M1;
            cs_n_q   <= 1'b0;
            a_d_q    <= 1'b1;
            if (esc_q) begin
              wr_n_q   <= 1'b0;
              ad_out_q <= dat_q;
            end else begin
              rd_n_q   <= 1'b0;
              ad_oe_q  <= 1'b0;
              ad_out_q <= 8'd0;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DATO: begin
          if (cnt_q == 8'd0) begin
            estado_q <= S_SEP2;
            cnt_q    <= SEP_M1;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            if (!esc_q) begin
              leido_q <= ad_in;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_SEP2: begin
          if (cnt_q == 8'd0) begin
            estado_q <= S_LISTO;
            cnt_q    <= 8'd0;
            ad_oe_q  <= 1'b0;
            ad_out_q <= 8'd0;
            listo_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_LISTO: begin
          estado_q  <= S_IDLE;
          ocupado_q <= 1'b0;
        end
        default: begin
          estado_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ad_out     = ad_out_q;
  assign ad_oe      = ad_oe_q;
  assign cs_n       = cs_n_q;
  assign rd_n       = rd_n_q;
  assign wr_n       = wr_n_q;
  assign a_d        = a_d_q;
  assign dato_leido = leido_q;
  assign ocupado    = ocupado_q;
  assign listo      = listo_q;

endmodule

// File: tb/tb_controlador_bus_rtc.sv
// Bench for controlador_bus_rtc: phase timing, reads, writes,
// request rejection, input stability, reset abort and back-to-back.
module tb_controlador_bus_rtc;

  localparam int F = 10;
  localparam int S = 5;
  localparam int L = 2 * F + 2 * S + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       inicio, escribir;
  logic [7:0] direccion, dato_es, ad_in;
  logic [7:0] ad_out, dato_leido;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d, ocupado, listo;

  logic       inicio2, escribir2;
  logic [7:0] direccion2, dato_es2, ad_in2;
  logic [7:0] ad_out2, dato_leido2;
  logic       ad_oe2, cs_n2, rd_n2, wr_n2, a_d2, ocupado2, listo2;

  controlador_bus_rtc #(.N_FASE(F), .N_SEP(S)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .escribir(escribir),
    .direccion(direccion), .dato_es(dato_es), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n),
    .wr_n(wr_n), .a_d(a_d), .dato_leido(dato_leido),
    .ocupado(ocupado), .listo(listo)
  );

  controlador_bus_rtc #(.N_FASE(1), .N_SEP(1)) dut2 (
    .clk(clk), .reset(reset), .inicio(inicio2), .escribir(escribir2),
    .direccion(direccion2), .dato_es(dato_es2), .ad_in(ad_in2),
    .ad_out(ad_out2), .ad_oe(ad_oe2), .cs_n(cs_n2), .rd_n(rd_n2),
    .wr_n(wr_n2), .a_d(a_d2), .dato_leido(dato_leido2),
    .ocupado(ocupado2), .listo(listo2)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_leido;
  bit inv_en = 1'b0;

  logic [6:0] o_ctl[0:L+1];
  logic [7:0] o_out[0:L+1];
  logic [7:0] o_leido[0:L+1];

  // {cs_n, rd_n, wr_n, a_d, ad_oe, ocupado, listo} by cycle after acceptance
  function automatic logic [6:0] exp_ctl(int t, logic esc);
    if (t <= F)                 return 7'b0100110;
    else if (t <= F + S)        return 7'b1110110;
    else if (t <= 2 * F + S)    return esc ? 7'b0101110 : 7'b0011010;
    else if (t <= 2 * F + 2 * S) return esc ? 7'b1111110 : 7'b1111010;
    else if (t == L)            return 7'b1111011;
    else                        return 7'b1111000;
  endfunction

  function automatic logic [7:0] exp_out(int t, logic [7:0] dir,
                                         logic [7:0] dat);
    return (t <= F + S) ? dir : dat;
  endfunction

  function automatic bit inv_ok(logic cs, logic rd, logic wr, logic oe,
                                logic ad, logic pcs, logic pad);
    if (!rd && !wr) return 1'b0;
    if (!rd && oe) return 1'b0;
    if (!cs && !(rd ^ wr)) return 1'b0;
    if (!cs && !pcs && (ad != pad)) return 1'b0;
    return 1'b1;
  endfunction

  logic pcs1 = 1'b1, pad1 = 1'b1, pcs2 = 1'b1, pad2 = 1'b1;

  // Bus safety invariants on both instances, every cycle
  always @(negedge clk) begin
    if (inv_en) begin
      vectors++;
      if (!inv_ok(cs_n, rd_n, wr_n, ad_oe, a_d, pcs1, pad1)) begin
        miscompares++;
        $display("FAIL inv_dut got cs%b rd%b wr%b oe%b ad%b want safe bus",
                 cs_n, rd_n, wr_n, ad_oe, a_d);
      end
      vectors++;
      if (!inv_ok(cs_n2, rd_n2, wr_n2, ad_oe2, a_d2, pcs2, pad2)) begin
        miscompares++;
        $display("FAIL inv_dut2 got cs%b rd%b wr%b oe%b ad%b want safe bus",
                 cs_n2, rd_n2, wr_n2, ad_oe2, a_d2);
      end
    end
    pcs1 = cs_n;  pad1 = a_d;
    pcs2 = cs_n2; pad2 = a_d2;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ocupado === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_idle got busy want idle within 100 cycles");
    end
  endtask

  task automatic run_txn(input logic esc, input logic [7:0] dir,
                         input logic [7:0] dat, input logic [7:0] rdv,
                         input bit scramble, input bit poke);
    wait_idle();
    escribir = esc; direccion = dir; dato_es = dat; inicio = 1'b1;
    for (int t = 1; t <= L + 1; t++) begin
      @(negedge clk);
      o_ctl[t]   = {cs_n, rd_n, wr_n, a_d, ad_oe, ocupado, listo};
      o_out[t]   = ad_out;
      o_leido[t] = dato_leido;
      inicio = poke && (t == 5 || t == 20);
      if (poke) direccion = 8'h10;
      if (scramble) begin
        direccion = 8'($urandom);
        dato_es   = 8'($urandom);
        escribir  = 1'($urandom);
      end
      ad_in = (rd_n === 1'b0) ? rdv : 8'($urandom);
    end
    inicio = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    inicio = 0; escribir = 0; direccion = 0; dato_es = 0; ad_in = 0;
    inicio2 = 0; escribir2 = 0; direccion2 = 8'h3C; dato_es2 = 8'hC3;
    ad_in2 = 8'h77;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe, ocupado, listo} !== 7'b1111000) begin
      miscompares++;
      $display("FAIL reset_ctl got %b want 1111000",
               {cs_n, rd_n, wr_n, a_d, ad_oe, ocupado, listo});
    end
    vectors++;
    if (ad_out !== 8'h00 || dato_leido !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data got %h/%h want 00/00", ad_out, dato_leido);
    end
    vectors++;
    if ({cs_n2, ocupado2, listo2} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_dut2 got %b want 100", {cs_n2, ocupado2, listo2});
    end
    model_leido = 8'h00;
    reset = 1'b1;
    inv_en = 1'b1;
  endtask

  task automatic test_write_read();
    logic       esc_t[2] = '{1'b1, 1'b0};
    logic [7:0] dir_t[2] = '{8'h21, 8'h22};
    logic [7:0] dat_t[2] = '{8'h45, 8'hA5};
    for (int n = 0; n < 2; n++) begin
      run_txn(esc_t[n], dir_t[n], dat_t[n], 8'h59, 1'b0, 1'b0);
      for (int t = 1; t <= L + 1; t++) begin
        logic [6:0] e = exp_ctl(t, esc_t[n]);
        logic [7:0] el = (!esc_t[n] && t > 2 * F + S) ? 8'h59 : model_leido;
        vectors++;
        if (o_ctl[t] !== e) begin
          miscompares++;
          $display("FAIL wr_rd%0d_ctl t=%0d got %b want %b", n, t, o_ctl[t], e);
        end
        if (e[2]) begin
          vectors++;
          if (o_out[t] !== exp_out(t, dir_t[n], dat_t[n])) begin
            miscompares++;
            $display("FAIL wr_rd%0d_out t=%0d got %h want %h", n, t,
                     o_out[t], exp_out(t, dir_t[n], dat_t[n]));
          end
        end
        vectors++;
        if (o_leido[t] !== el) begin
          miscompares++;
          $display("FAIL wr_rd%0d_leido t=%0d got %h want %h", n, t,
                   o_leido[t], el);
        end
      end
      if (!esc_t[n]) model_leido = 8'h59;
    end
  endtask

  task automatic test_busy();
    run_txn(1'b1, 8'h21, 8'h45, 8'h00, 1'b0, 1'b1);
    for (int t = 1; t <= L + 1; t++) begin
      logic [6:0] e = exp_ctl(t, 1'b1);
      vectors++;
      if (o_ctl[t] !== e) begin
        miscompares++;
        $display("FAIL busy_ctl t=%0d got %b want %b", t, o_ctl[t], e);
      end
      if (e[2]) begin
        vectors++;
        if (o_out[t] !== exp_out(t, 8'h21, 8'h45)) begin
          miscompares++;
          $display("FAIL busy_out t=%0d got %h want %h", t, o_out[t],
                   exp_out(t, 8'h21, 8'h45));
        end
      end
    end
    wait_idle();
    vectors++;
    if (ocupado !== 1'b0 || cs_n !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_queued got ocupado=%b cs_n=%b want 0/1",
               ocupado, cs_n);
    end
  endtask

  task automatic test_stability();
    for (int n = 0; n < 6; n++) begin
      logic       esc = 1'($urandom);
      logic [7:0] dir = 8'($urandom);
      logic [7:0] dat = 8'($urandom);
      logic [7:0] rdv = 8'($urandom);
      run_txn(esc, dir, dat, rdv, 1'b1, 1'b0);
      for (int t = 1; t <= L + 1; t++) begin
        logic [6:0] e = exp_ctl(t, esc);
        logic [7:0] el = (!esc && t > 2 * F + S) ? rdv : model_leido;
        vectors++;
        if (o_ctl[t] !== e) begin
          miscompares++;
          $display("FAIL stab%0d_ctl t=%0d got %b want %b", n, t, o_ctl[t], e);
        end
        if (e[2]) begin
          vectors++;
          if (o_out[t] !== exp_out(t, dir, dat)) begin
            miscompares++;
            $display("FAIL stab%0d_out t=%0d got %h want %h", n, t,
                     o_out[t], exp_out(t, dir, dat));
          end
        end
        vectors++;
        if (o_leido[t] !== el) begin
          miscompares++;
          $display("FAIL stab%0d_leido t=%0d got %h want %h", n, t,
                   o_leido[t], el);
        end
      end
      if (!esc) model_leido = rdv;
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    escribir = 1'b1; direccion = 8'h21; dato_es = 8'h45; inicio = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      inicio = 1'b0;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({cs_n, rd_n, wr_n, ad_oe, ocupado, listo} !== 6'b111000 ||
          dato_leido !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_mid%0d got %b/%h want 111000/00", i,
                 {cs_n, rd_n, wr_n, ad_oe, ocupado, listo}, dato_leido);
      end
    end
    reset = 1'b1;
    model_leido = 8'h00;
    @(negedge clk);
    vectors++;
    if ({cs_n, wr_n, ocupado} !== 3'b110) begin
      miscompares++;
      $display("FAIL reset_after got %b want 110", {cs_n, wr_n, ocupado});
    end
  endtask

  task automatic test_back_to_back();
    inicio2 = 1'b1;
    for (int t = 1; t <= 36; t++) begin
      logic [1:0] e;
      @(negedge clk);
      e = {(t % 6) != 0, (t % 6) == 5};
      vectors++;
      if ({ocupado2, listo2} !== e) begin
        miscompares++;
        $display("FAIL b2b t=%0d got ocupado,listo=%b want %b", t,
                 {ocupado2, listo2}, e);
      end
      if (ad_oe2 === 1'b1) begin
        vectors++;
        if (ad_out2 !== (a_d2 ? 8'hC3 : 8'h3C)) begin
          miscompares++;
          $display("FAIL b2b_out t=%0d got %h want %h", t, ad_out2,
                   a_d2 ? 8'hC3 : 8'h3C);
        end
      end
      vectors++;
      if (dato_leido2 !== 8'h00 && dato_leido2 !== 8'h77) begin
        miscompares++;
        $display("FAIL b2b_leido t=%0d got %h want 00 or 77", t, dato_leido2);
      end
      escribir2 = 1'($urandom);
    end
    inicio2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_busy();
    test_stability();
    test_reset_mid();
    test_back_to_back();
    repeat (8) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
